// File: rtl/bram_arbiter_if.sv
// bram_arbiter_if: request/response bundle for two BRAM clients plus the BRAM port A/B controls.
interface bram_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    logic                  c0_req, c1_req, c0_we, c1_we;
    logic [ADDR_WIDTH-1:0] c0_addr, c1_addr;
    logic [DATA_WIDTH-1:0] c0_wdata, c1_wdata;
    logic                  c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
    logic [DATA_WIDTH-1:0] c0_rdata, c1_rdata;
    logic                  bram_ena, bram_wea, bram_enb, bram_rstb;
    logic [ADDR_WIDTH-1:0] bram_addra, bram_addrb;
    logic [DATA_WIDTH-1:0] bram_dina, bram_doutb;
    modport slave (
        input  c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata, bram_doutb,
        output c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
        output bram_ena, bram_wea, bram_enb, bram_rstb, bram_addra, bram_addrb, bram_dina
    );
    modport master (
        output c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata, bram_doutb,
        input  c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
        input  bram_ena, bram_wea, bram_enb, bram_rstb, bram_addra, bram_addrb, bram_dina
    );
endinterface

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin two-client arbiter for a dual-port BRAM (port A write, port B read).
// Optional BRAM_ARBITER_WFWD_EN forwards same-cycle same-address write data to the read.
module bram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input logic           clock_12mhz,
    input logic           reset,
    bram_arbiter_if.slave bus
);
    logic                  w_wr0, w_wr1, w_rd0, w_rd1, w_ga0, w_ga1, w_gb0, w_gb1;
    logic                  r_lp_a, r_lp_b, r_ena, r_enb, r_id1, r_rv0, r_rv1;
    logic [ADDR_WIDTH-1:0] r_addra, r_addrb;
    logic [DATA_WIDTH-1:0] r_dina, w_rdata;
    assign w_wr0 = bus.c0_req & bus.c0_we;
    assign w_wr1 = bus.c1_req & bus.c1_we;
    assign w_rd0 = bus.c0_req & ~bus.c0_we;
    assign w_rd1 = bus.c1_req & ~bus.c1_we;
    // Client 0 wins a contended port only when client 1 was granted last.
    assign w_ga0 = w_wr0 & (~w_wr1 | r_lp_a);
    assign w_ga1 = w_wr1 & ~w_ga0;
    assign w_gb0 = w_rd0 & (~w_rd1 | r_lp_b);
    assign w_gb1 = w_rd1 & ~w_gb0;
    assign bus.c0_gnt = ~reset & (w_ga0 | w_gb0);
    assign bus.c1_gnt = ~reset & (w_ga1 | w_gb1);
    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            r_lp_a  <= 1'b1;
            r_lp_b  <= 1'b1;
            r_ena   <= 1'b0;
            r_enb   <= 1'b0;
            r_id1   <= 1'b0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
            r_addra <= '0;
            r_addrb <= '0;
            r_dina  <= '0;
        end else begin
            r_ena <= w_ga0 | w_ga1;
            r_enb <= w_gb0 | w_gb1;
            if (w_ga0 | w_ga1) begin
                r_lp_a  <= w_ga1;
                r_addra <= w_ga1 ? bus.c1_addr : bus.c0_addr;
                r_dina  <= w_ga1 ? bus.c1_wdata : bus.c0_wdata;
            end
            if (w_gb0 | w_gb1) begin
                r_lp_b  <= w_gb1;
                r_addrb <= w_gb1 ? bus.c1_addr : bus.c0_addr;
                r_id1   <= w_gb1;
            end
            r_rv0 <= r_enb & ~r_id1;
            r_rv1 <= r_enb & r_id1;
        end
    end
`ifdef BRAM_ARBITER_WFWD_EN
    logic                  r_fwd;
    logic [DATA_WIDTH-1:0] r_fwd_data;
    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_fwd      <= r_ena & r_enb & (r_addra == r_addrb);
            r_fwd_data <= r_dina;
        end
    end
    assign w_rdata = r_fwd ? r_fwd_data : bus.bram_doutb;
`else
    assign w_rdata = bus.bram_doutb;
`endif
    assign bus.c0_rvalid  = r_rv0;
    assign bus.c1_rvalid  = r_rv1;
    assign bus.c0_rdata   = r_rv0 ? w_rdata : '0;
    assign bus.c1_rdata   = r_rv1 ? w_rdata : '0;
    assign bus.bram_ena   = r_ena;
    assign bus.bram_wea   = r_ena;
    assign bus.bram_addra = r_addra;
    assign bus.bram_dina  = r_dina;
    assign bus.bram_enb   = r_enb;
    assign bus.bram_addrb = r_addrb;
    assign bus.bram_rstb  = reset;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed checks of bram_arbiter against a read-first BRAM model.
module tb_bram_arbiter;
    localparam int AW = 10;
    localparam int DW = 16;
    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int bad = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clock_12mhz(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.bram_ena & bus.bram_wea) mem[bus.bram_addra] <= bus.bram_dina;
        if (bus.bram_rstb) bus.bram_doutb <= '0;
        else if (bus.bram_enb) bus.bram_doutb <= mem[bus.bram_addrb];
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic clr_req;
        bus.c0_req = 0; bus.c1_req = 0; bus.c0_we = 0; bus.c1_we = 0;
        bus.c0_addr = '0; bus.c1_addr = '0; bus.c0_wdata = '0; bus.c1_wdata = '0;
    endtask
    task automatic do_reset;
        reset = 1; clr_req;
        tick; tick;
        reset = 0;
    endtask
    task automatic test_reset;
        bus.c0_req = 1; bus.c0_we = 1; bus.c1_req = 1; bus.c1_we = 0;
        @(negedge clk);
        total++; if (bus.c0_gnt !== 1'b0) begin bad++; $display("FAIL rst_c0_gnt: got %b want 0", bus.c0_gnt); end
        total++; if (bus.c1_gnt !== 1'b0) begin bad++; $display("FAIL rst_c1_gnt: got %b want 0", bus.c1_gnt); end
        total++; if ({bus.bram_ena, bus.bram_wea, bus.bram_enb} !== 3'b000) begin bad++; $display("FAIL rst_en: got %b want 000", {bus.bram_ena, bus.bram_wea, bus.bram_enb}); end
        total++; if ({bus.c0_rvalid, bus.c1_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid: got %b want 00", {bus.c0_rvalid, bus.c1_rvalid}); end
        total++; if ({bus.bram_addra, bus.bram_addrb, bus.bram_dina} !== '0) begin bad++; $display("FAIL rst_regs: got %h %h %h want 0", bus.bram_addra, bus.bram_addrb, bus.bram_dina); end
        total++; if (bus.bram_rstb !== 1'b1) begin bad++; $display("FAIL rst_rstb: got %b want 1", bus.bram_rstb); end
        clr_req; tick;
        reset = 0;
        @(negedge clk);
        total++; if (bus.bram_rstb !== 1'b0) begin bad++; $display("FAIL rstb_release: got %b want 0", bus.bram_rstb); end
        tick;
    endtask
    task automatic test_write_read;
        bus.c0_req = 1; bus.c0_we = 1; bus.c0_addr = AW'(5); bus.c0_wdata = 16'h1234;
        @(negedge clk);
        total++; if ({bus.c0_gnt, bus.c1_gnt} !== 2'b10) begin bad++; $display("FAIL wr_gnt: got %b want 10", {bus.c0_gnt, bus.c1_gnt}); end
        tick; clr_req;
        @(negedge clk);
        total++; if ({bus.bram_ena, bus.bram_wea, bus.bram_enb} !== 3'b110) begin bad++; $display("FAIL wr_en: got %b want 110", {bus.bram_ena, bus.bram_wea, bus.bram_enb}); end
        total++; if (bus.bram_addra !== AW'(5) || bus.bram_dina !== 16'h1234) begin bad++; $display("FAIL wr_cmd: got %h/%h want 005/1234", bus.bram_addra, bus.bram_dina); end
        tick;
        @(negedge clk);
        total++; if (bus.bram_ena !== 1'b0 || bus.bram_addra !== AW'(5)) begin bad++; $display("FAIL idle_hold: got en=%b a=%h want 0/005", bus.bram_ena, bus.bram_addra); end
        tick; tick;
        bus.c1_req = 1; bus.c1_we = 0; bus.c1_addr = AW'(5);
        @(negedge clk);
        total++; if ({bus.c0_gnt, bus.c1_gnt} !== 2'b01) begin bad++; $display("FAIL rd_gnt: got %b want 01", {bus.c0_gnt, bus.c1_gnt}); end
        tick; clr_req;
        @(negedge clk);
        total++; if (bus.bram_enb !== 1'b1 || bus.bram_addrb !== AW'(5)) begin bad++; $display("FAIL rd_cmd: got en=%b a=%h want 1/005", bus.bram_enb, bus.bram_addrb); end
        total++; if (bus.c1_rvalid !== 1'b0) begin bad++; $display("FAIL rd_early: got %b want 0", bus.c1_rvalid); end
        tick;
        @(negedge clk);
        total++; if (bus.c1_rvalid !== 1'b1 || bus.c1_rdata !== 16'h1234) begin bad++; $display("FAIL rd_data: got v=%b d=%h want 1/1234", bus.c1_rvalid, bus.c1_rdata); end
        total++; if (bus.c0_rvalid !== 1'b0 || bus.c0_rdata !== '0) begin bad++; $display("FAIL rd_other: got v=%b d=%h want 0/0000", bus.c0_rvalid, bus.c0_rdata); end
        tick;
        @(negedge clk);
        total++; if (bus.c1_rvalid !== 1'b0 || bus.c1_rdata !== '0) begin bad++; $display("FAIL rd_after: got v=%b d=%h want 0/0000", bus.c1_rvalid, bus.c1_rdata); end
        tick;
    endtask
    task automatic test_contention;
        do_reset;
        for (int k = 0; k < 6; k++) begin
            bus.c0_req = 1; bus.c0_we = 1; bus.c0_addr = AW'(10 + k); bus.c0_wdata = DW'(k);
            bus.c1_req = 1; bus.c1_we = 1; bus.c1_addr = AW'(20 + k); bus.c1_wdata = DW'(100 + k);
            @(negedge clk);
            total++; if ({bus.c0_gnt, bus.c1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_gnt%0d: got %b want %b", k, {bus.c0_gnt, bus.c1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01); end
            if (k > 0) begin
                total++; if (bus.bram_addra !== AW'((k % 2 == 1) ? 9 + k : 19 + k)) begin bad++; $display("FAIL rr_addr%0d: got %h want %h", k, bus.bram_addra, AW'((k % 2 == 1) ? 9 + k : 19 + k)); end
            end
            tick;
        end
        clr_req;
        @(negedge clk);
        total++; if (bus.bram_ena !== 1'b1 || bus.bram_addra !== AW'(25) || bus.bram_dina !== DW'(105)) begin bad++; $display("FAIL rr_last: got en=%b a=%h d=%h want 1/019/0069", bus.bram_ena, bus.bram_addra, bus.bram_dina); end
        tick;
    endtask
    task automatic test_parallel;
        bus.c0_req = 1; bus.c0_we = 1; bus.c0_addr = AW'(9); bus.c0_wdata = 16'h0BEE;
        bus.c1_req = 1; bus.c1_we = 0; bus.c1_addr = AW'(3);
        @(negedge clk);
        total++; if ({bus.c0_gnt, bus.c1_gnt} !== 2'b11) begin bad++; $display("FAIL par_gnt: got %b want 11", {bus.c0_gnt, bus.c1_gnt}); end
        tick; clr_req;
        @(negedge clk);
        total++; if ({bus.bram_ena, bus.bram_enb} !== 2'b11) begin bad++; $display("FAIL par_en: got %b want 11", {bus.bram_ena, bus.bram_enb}); end
        total++; if (bus.bram_addra !== AW'(9) || bus.bram_addrb !== AW'(3)) begin bad++; $display("FAIL par_addr: got %h/%h want 009/003", bus.bram_addra, bus.bram_addrb); end
        tick; tick;
    endtask
    task automatic test_forward;
        logic [DW-1:0] exp_d;
`ifdef BRAM_ARBITER_WFWD_EN
        exp_d = 16'h5555;
`else
        exp_d = 16'hAAAA;
`endif
        bus.c0_req = 1; bus.c0_we = 1; bus.c0_addr = AW'(7); bus.c0_wdata = 16'hAAAA;
        @(negedge clk);
        total++; if (bus.c0_gnt !== 1'b1) begin bad++; $display("FAIL fwd_pre: got %b want 1", bus.c0_gnt); end
        tick; clr_req; tick;
        bus.c0_req = 1; bus.c0_we = 1; bus.c0_addr = AW'(7); bus.c0_wdata = 16'h5555;
        bus.c1_req = 1; bus.c1_we = 0; bus.c1_addr = AW'(7);
        @(negedge clk);
        total++; if ({bus.c0_gnt, bus.c1_gnt} !== 2'b11) begin bad++; $display("FAIL fwd_gnt: got %b want 11", {bus.c0_gnt, bus.c1_gnt}); end
        tick; clr_req; tick;
        @(negedge clk);
        total++; if (bus.c1_rvalid !== 1'b1 || bus.c1_rdata !== exp_d) begin bad++; $display("FAIL fwd_data: got v=%b d=%h want 1/%h", bus.c1_rvalid, bus.c1_rdata, exp_d); end
        tick;
        bus.c1_req = 1; bus.c1_we = 0; bus.c1_addr = AW'(7);
        tick; clr_req; tick;
        @(negedge clk);
        total++; if (bus.c1_rvalid !== 1'b1 || bus.c1_rdata !== 16'h5555) begin bad++; $display("FAIL fwd_after: got v=%b d=%h want 1/5555", bus.c1_rvalid, bus.c1_rdata); end
        tick;
    endtask
    task automatic test_reset_mid;
        do_reset;
        bus.c0_req = 1; bus.c0_we = 0; bus.c0_addr = AW'(5);
        @(negedge clk);
        total++; if (bus.c0_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt: got %b want 1", bus.c0_gnt); end
        tick;
        clr_req; bus.c1_req = 1; bus.c1_we = 1;
        reset = 1;
        @(negedge clk);
        total++; if ({bus.c0_gnt, bus.c1_gnt, bus.bram_ena, bus.bram_enb, bus.c0_rvalid, bus.c1_rvalid} !== 6'b0) begin bad++; $display("FAIL mid_outs: got %b want 000000", {bus.c0_gnt, bus.c1_gnt, bus.bram_ena, bus.bram_enb, bus.c0_rvalid, bus.c1_rvalid}); end
        total++; if (bus.bram_addrb !== '0 || bus.c0_rdata !== '0) begin bad++; $display("FAIL mid_regs: got %h/%h want 000/0000", bus.bram_addrb, bus.c0_rdata); end
        tick;
        @(negedge clk);
        total++; if (bus.c0_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rv0: got %b want 0", bus.c0_rvalid); end
        tick;
        clr_req; reset = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (bus.c0_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rv%0d: got %b want 0", k + 1, bus.c0_rvalid); end
            tick;
        end
        bus.c0_req = 1; bus.c0_we = 1; bus.c1_req = 1; bus.c1_we = 1;
        @(negedge clk);
        total++; if ({bus.c0_gnt, bus.c1_gnt} !== 2'b10) begin bad++; $display("FAIL mid_first: got %b want 10", {bus.c0_gnt, bus.c1_gnt}); end
        tick; clr_req; tick;
    endtask
    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            bus.c0_req = 1; bus.c0_we = 1; bus.c0_addr = AW'(i); bus.c0_wdata = DW'(16'hC000 + i);
            @(negedge clk);
            total++; if (bus.c0_gnt !== 1'b1) begin bad++; $display("FAIL b2b_wr%0d: got %b want 1", i, bus.c0_gnt); end
            tick;
        end
        clr_req; tick; tick;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin bus.c1_req = 1; bus.c1_we = 0; bus.c1_addr = AW'(k); end
            else clr_req;
            @(negedge clk);
            if (k < 4) begin
                total++; if (bus.c1_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt%0d: got %b want 1", k, bus.c1_gnt); end
            end
            total++; if (bus.c1_rvalid !== (k >= 2 && k < 6)) begin bad++; $display("FAIL b2b_rv%0d: got %b want %b", k, bus.c1_rvalid, (k >= 2 && k < 6)); end
            if (k >= 2 && k < 6) begin
                total++; if (bus.c1_rdata !== DW'(16'hC000 + k - 2)) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", k, bus.c1_rdata, DW'(16'hC000 + k - 2)); end
            end
            tick;
        end
    endtask
    initial begin
        reset = 1; clr_req;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_write_read;
        test_contention;
        test_parallel;
        test_forward;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-client arbiter and sequencer for the dual-port block RAM (`bram`: port A write, port B read). It lets two independent requesters, for example a flash/microSD loader and a channel capture engine, share the RAM with round-robin fairness. Each port is arbitrated independently. It sits between the requesters and the `bram` instance in the top level, and drives every `bram` control input.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: BRAM address width.
- `DATA_WIDTH`, default 16: BRAM data width.

Ports:
- `clock_12mhz`  in  1  sole clock; also drives `bram` `clka`/`clkb`.
- `reset`  in  1  asynchronous, active-high.
- `c0_req`, `c1_req`  in  1  request valid; must be held until granted.
- `c0_we`, `c1_we`  in  1  1 = write, 0 = read; stable while `req` is high.
- `c0_addr`, `c1_addr`  in  ADDR_WIDTH  request address.
- `c0_wdata`, `c1_wdata`  in  DATA_WIDTH  write data.
- `c0_gnt`, `c1_gnt`  out  1  combinational accept; the request is consumed on the clock edge where `req & gnt`.
- `c0_rvalid`, `c1_rvalid`  out  1  one-cycle read-data strobe.
- `c0_rdata`, `c1_rdata`  out  DATA_WIDTH  read data, valid when `rvalid` is high.
- `bram_ena`, `bram_wea`  out  1  port A enable / write enable.
- `bram_addra`  out  ADDR_WIDTH  port A address.
- `bram_dina`  out  DATA_WIDTH  port A write data.
- `bram_enb`  out  1  port B enable.
- `bram_addrb`  out  ADDR_WIDTH  port B address.
- `bram_rstb`  out  1  port B output reset; tied to `reset`.
- `bram_doutb`  in  DATA_WIDTH  port B read data; 1-cycle latency after the `bram_enb` cycle.

## Operation
- Write requests (`req & we`) compete for port A. Read requests (`req & !we`) compete for port B.
- Port A and port B are arbitrated independently. One client writing and the other reading are both granted in the same cycle.
- Each port keeps a 1-bit last-grant pointer `lp_a` / `lp_b`.
  - Both clients contending for one port: grant goes to the client ≠ pointer.
  - Single requester: granted immediately.
  - The pointer updates to the granted client on every grant to that port.
  - Reset value of both pointers: 1, so client 0 wins the first contention.
- Granted write: on the next cycle, `bram_ena = bram_wea = 1` and `bram_addra`/`bram_dina` equal the registered request.
- Granted read: on the next cycle, `bram_enb = 1` and `bram_addrb` equals the registered address. A 2-stage shift pipeline carries the client ID and a valid bit to the return path.
- Read return:
  - `cN_rvalid` is a registered pipeline bit.
  - `cN_rdata = bram_doutb` for the tagged client. It is 0 for the other client and when `rvalid` is low.
- Idle cycles: enables are 0. Address and data registers hold their last values.
- No request queueing: at most one outstanding grant per client per cycle. Reads are pipelined, so back-to-back read grants to one client are allowed every cycle.
- Reset, including mid-operation:
  - All enables, `gnt`, `rvalid` and the pipeline valid bits clear immediately.
  - In-flight reads are dropped and no `rvalid` is produced for them.
  - Address and data registers reset to 0.

## Timing
- Grant at edge N, where `gnt` is high in cycle N.
- BRAM command is visible in cycle N+1.
- Write takes effect at the N+1→N+2 edge.
- Read data and `rvalid` are present in cycle N+2. Read latency is exactly 2 cycles from grant.
- Sustained throughput: 1 write plus 1 read per cycle.
- Under constant contention on one port, grants strictly alternate 0,1,0,1.
- The maximum wait for a held request is 1 cycle.
- Same-cycle write and read to the same address: governed by the Configuration macro below.

## Configuration
- Macro `BRAM_ARBITER_WFWD_EN` defined: write-to-read forwarding is enabled.
  - Condition: port A and port B issue commands to the same address in the same cycle.
  - Result: the read returns that cycle's `bram_dina`, registered alongside the pipeline.
- Macro undefined: the read returns `bram_doutb` unmodified, i.e. the BRAM's native read-first (old) data.

## Test plan
- Reset, then client 0 writes 0x1234 to addr 5; 3 cycles later client 1 reads addr 5 → `c1_rvalid` pulses exactly 2 cycles after `c1_gnt`, with `c1_rdata` = 0x1234.
- Both clients hold write requests for 6 cycles → `c0_gnt`/`c1_gnt` pattern is 0,1,0,1,0,1, starting with client 0 after reset.
- Client 0 writes while client 1 reads, same cycle → both `gnt` high in that cycle; `bram_ena` and `bram_enb` both high in the next cycle.
- Pre-load addr 7 = 0xAAAA, then a same-cycle write of 0x5555 and read at addr 7 → returns 0x5555 with `BRAM_ARBITER_WFWD_EN`, 0xAAAA without it.
- Issue a read grant, then assert `reset` in cycle N+1 → no `rvalid` ever appears; all outputs are 0 during reset; the first contention after release goes to client 0.
- Client 1 issues 4 consecutive reads of addrs 0–3 → 4 consecutive `c1_rvalid` cycles carrying the data in address order.
